// File: rtl/pht_update_queue.sv
// pht_update_queue
// Buffers resolved conditional-branch PHT updates and drains them into the
// PHT write port one per cycle, yielding to the fetch-side PHT read whenever
// both would hit the same bank. Updates are hints: when the queue is full and
// nothing retires, the update is dropped and counted instead of stalling.
//
// Optional feature: define RSD_PHT_UPDATE_QUEUE_BYPASS_EN to let an update that
// arrives while the queue is empty (and does not bank-conflict with the fetch
// read) be written to the PHT in the same cycle without being enqueued.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   upd_*             branch result (valid, cond-branch flag, index, counter
//                     read at prediction, resolved direction)
//   rd_valid/rd_index fetch-side PHT read this cycle
//   wr_en/wr_index/wr_value  PHT write port
//   q_count/q_full/q_empty   queue occupancy status
//   drop_count        saturating count of dropped updates
module pht_update_queue #(
  parameter int QUEUE_SIZE      = 32,
  parameter int PHT_INDEX_WIDTH = 10,
  parameter int PHT_ENTRY_WIDTH = 2,
  parameter int BANK_BIT_WIDTH  = 1,
  parameter int DROP_CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            upd_valid,
  input  logic                            upd_is_cond_br,
  input  logic [PHT_INDEX_WIDTH-1:0]      upd_index,
  input  logic [PHT_ENTRY_WIDTH-1:0]      upd_prev_value,
  input  logic                            upd_exec_taken,
  input  logic                            rd_valid,
  input  logic [PHT_INDEX_WIDTH-1:0]      rd_index,
  output logic                            wr_en,
  output logic [PHT_INDEX_WIDTH-1:0]      wr_index,
  output logic [PHT_ENTRY_WIDTH-1:0]      wr_value,
  output logic [$clog2(QUEUE_SIZE):0]     q_count,
  output logic                            q_full,
  output logic                            q_empty,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;

  // Saturating 2-bit-style counter update; never wraps at either end.
  function automatic logic [PHT_ENTRY_WIDTH-1:0] next_ctr(
    input logic [PHT_ENTRY_WIDTH-1:0] prev,
    input logic                       taken
  );
    logic [PHT_ENTRY_WIDTH-1:0] res;
    if (taken) begin
      res = (prev == {PHT_ENTRY_WIDTH{1'b1}}) ? prev : prev + {{(PHT_ENTRY_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      res = (prev == {PHT_ENTRY_WIDTH{1'b0}}) ? prev : prev - {{(PHT_ENTRY_WIDTH-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  logic [PHT_INDEX_WIDTH-1:0] idx_mem [QUEUE_SIZE];
  logic [PHT_ENTRY_WIDTH-1:0] val_mem [QUEUE_SIZE];

  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic                       push_req_s, empty_s, full_s, pop_s, byp_s;
  logic                       accept_s, drop_s, q_conflict_s;
  logic [PHT_ENTRY_WIDTH-1:0] new_val_s;
  logic [PHT_INDEX_WIDTH-1:0] head_idx_s;
  logic [PHT_ENTRY_WIDTH-1:0] head_val_s;

  assign push_req_s = upd_valid & upd_is_cond_br;
  assign new_val_s  = next_ctr(upd_prev_value, upd_exec_taken);
  assign empty_s    = (count_q == {CNT_W{1'b0}});
  assign full_s     = (count_q == CNT_W'(QUEUE_SIZE));
  assign head_idx_s = idx_mem[head_q];
  assign head_val_s = val_mem[head_q];

  // The head entry retires unless fetch reads the same bank this cycle.
  assign q_conflict_s = rd_valid &
                        (head_idx_s[BANK_BIT_WIDTH-1:0] == rd_index[BANK_BIT_WIDTH-1:0]);
  assign pop_s        = ~empty_s & ~q_conflict_s;

`ifdef RSD_PHT_UPDATE_QUEUE_BYPASS_EN
  // Empty queue and no bank clash: write the update straight through.
  assign byp_s = empty_s & push_req_s &
                 ~(rd_valid & (upd_index[BANK_BIT_WIDTH-1:0] == rd_index[BANK_BIT_WIDTH-1:0]));
`else
  assign byp_s = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a full queue still accepts.
  assign accept_s = push_req_s & (~full_s | pop_s) & ~byp_s;
  assign drop_s   = push_req_s & full_s & ~pop_s;

  // PHT write port: bypassed update, else head entry, else idle zeros.
  always_comb begin
    wr_en    = 1'b0;
    wr_index = {PHT_INDEX_WIDTH{1'b0}};
    wr_value = {PHT_ENTRY_WIDTH{1'b0}};
    if (byp_s) begin
      wr_en    = 1'b1;
      wr_index = upd_index;
      wr_value = new_val_s;
    end else if (!empty_s) begin
      wr_en    = pop_s;
      wr_index = head_idx_s;
      wr_value = head_val_s;
    end else begin
      wr_en    = 1'b0;
    end
  end

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (pop_s) begin
      head_d = head_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end
    if (accept_s) begin
      tail_d = tail_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    if (drop_s && (drop_q != {DROP_CNT_WIDTH{1'b1}})) begin
      drop_d = drop_q + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      drop_d = drop_q;
    end
  end

  // Queue control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      drop_q  <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage; contents are only meaningful between tail and head.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      idx_mem[tail_q] <= upd_index;
      val_mem[tail_q] <= new_val_s;
    end
  end

  assign q_count    = count_q;
  assign q_full     = full_s;
  assign q_empty    = empty_s;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pht_update_queue.sv
module tb_pht_update_queue;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_is_cond_br;
  logic [9:0]  upd_index;
  logic [1:0]  upd_prev_value;
  logic        upd_exec_taken;
  logic        rd_valid;
  logic [9:0]  rd_index;
  logic        wr_en;
  logic [9:0]  wr_index;
  logic [1:0]  wr_value;
  logic [5:0]  q_count;
  logic        q_full;
  logic        q_empty;
  logic [15:0] drop_count;

  int checks;
  int errors;

  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];

  pht_update_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .upd_valid      (upd_valid),
    .upd_is_cond_br (upd_is_cond_br),
    .upd_index      (upd_index),
    .upd_prev_value (upd_prev_value),
    .upd_exec_taken (upd_exec_taken),
    .rd_valid       (rd_valid),
    .rd_index       (rd_index),
    .wr_en          (wr_en),
    .wr_index       (wr_index),
    .wr_value       (wr_value),
    .q_count        (q_count),
    .q_full         (q_full),
    .q_empty        (q_empty),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every PHT write mid-cycle, once inputs have settled.
  always @(negedge clk) begin
    if (rst_n && wr_en) got_q.push_back({wr_index, wr_value});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [9:0] idx, input logic [1:0] prev, input logic tk);
    upd_valid      = 1'b1;
    upd_is_cond_br = 1'b1;
    upd_index      = idx;
    upd_prev_value = prev;
    upd_exec_taken = tk;
    tick();
    upd_valid      = 1'b0;
    upd_is_cond_br = 1'b0;
    #1;
  endtask

  task automatic drain();
    rd_valid = 1'b0;
    #1;
    for (int k = 0; k < 48 && !q_empty; k++) tick();
    tick();
    chk("drain_empty", 32'(q_empty), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // Streaming-test vectors: prev, taken, expected new counter.
  logic [1:0] s_prev [4];
  logic       s_tk   [4];
  logic [1:0] s_exp  [4];

  initial begin
    checks = 0;
    errors = 0;
    s_prev[0] = 2'd0; s_tk[0] = 1'b1; s_exp[0] = 2'd1;
    s_prev[1] = 2'd3; s_tk[1] = 1'b0; s_exp[1] = 2'd2;
    s_prev[2] = 2'd2; s_tk[2] = 1'b1; s_exp[2] = 2'd3;
    s_prev[3] = 2'd1; s_tk[3] = 1'b0; s_exp[3] = 2'd0;

    rst_n = 1'b0; upd_valid = 1'b0; upd_is_cond_br = 1'b0;
    upd_index = 10'd0; upd_prev_value = 2'd0; upd_exec_taken = 1'b0;
    rd_valid = 1'b0; rd_index = 10'd0;
    #1;
    chk("rst_empty", 32'(q_empty), 32'd1);
    chk("rst_full", 32'(q_full), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_index", 32'(wr_index), 32'd0);
    chk("rst_wr_value", 32'(wr_value), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();
    chk("idle_empty", 32'(q_empty), 32'd0 + 32'd1);
    chk("idle_wr_en", 32'(wr_en), 32'd0);

    // Single pushes, one retire each.
    push_one(10'h005, 2'd1, 1'b1);
`ifndef RSD_PHT_UPDATE_QUEUE_BYPASS_EN
    chk("single_wr_en", 32'(wr_en), 32'd1);
    chk("single_wr_index", 32'(wr_index), 32'h005);
    chk("single_wr_value", 32'(wr_value), 32'd2);
`endif
    tick();
    chk("single_empty_after", 32'(q_empty), 32'd1);
    exp_q.push_back({10'h005, 2'd2});
    push_one(10'h005, 2'd3, 1'b1); tick();
    exp_q.push_back({10'h005, 2'd3});
    push_one(10'h005, 2'd0, 1'b0); tick();
    exp_q.push_back({10'h005, 2'd0});
    check_log("single_log");

    // Conflict stall: bank 0 read blocks a bank 0 write.
    rd_valid = 1'b1; rd_index = 10'h006;
    push_one(10'h004, 2'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("stall_wr_en", 32'(wr_en), 32'd0);
      chk("stall_count", 32'(q_count), 32'd1);
      tick();
    end
    rd_index = 10'h007;
    #1;
    chk("unstall_wr_en", 32'(wr_en), 32'd1);
    chk("unstall_wr_index", 32'(wr_index), 32'h004);
    chk("unstall_wr_value", 32'(wr_value), 32'd1);
    tick();
    chk("unstall_empty", 32'(q_empty), 32'd1);
    exp_q.push_back({10'h004, 2'd1});
    check_log("stall_log");

    // Overflow under persistent conflict.
    rd_valid = 1'b1; rd_index = 10'h000;
    upd_valid = 1'b1; upd_is_cond_br = 1'b1;
    upd_prev_value = 2'd2; upd_exec_taken = 1'b1;
    for (int i = 0; i < 32; i++) begin
      upd_index = 10'(2 * i);
      exp_q.push_back({10'(2 * i), 2'd3});
      tick();
    end
    chk("ovf_full", 32'(q_full), 32'd1);
    chk("ovf_count", 32'(q_count), 32'd32);
    chk("ovf_drop0", 32'(drop_count), 32'd0);
    for (int i = 32; i < 34; i++) begin
      upd_index = 10'(2 * i);
      tick();
    end
    chk("ovf_drop2", 32'(drop_count), 32'd2);
    chk("ovf_full2", 32'(q_full), 32'd1);
    // Full with a same-cycle pop: push accepted, occupancy unchanged.
    rd_valid = 1'b0; upd_index = 10'h101; upd_prev_value = 2'd0; upd_exec_taken = 1'b1;
    #1;
    chk("ovf_pop_wr_en", 32'(wr_en), 32'd1);
    chk("ovf_pop_wr_index", 32'(wr_index), 32'h000);
    tick();
    upd_valid = 1'b0; upd_is_cond_br = 1'b0;
    #1;
    chk("ovf_pp_count", 32'(q_count), 32'd32);
    chk("ovf_pp_drop", 32'(drop_count), 32'd2);
    exp_q.push_back({10'h101, 2'd1});
    drain();
    check_log("ovf_log");

    // Streaming 40 entries wraps the pointers; order must be preserved.
    rd_valid = 1'b0;
    upd_valid = 1'b1; upd_is_cond_br = 1'b1;
    for (int i = 0; i < 40; i++) begin
      upd_index      = 10'(10'h200 + 7 * i);
      upd_prev_value = s_prev[i % 4];
      upd_exec_taken = s_tk[i % 4];
      exp_q.push_back({10'(10'h200 + 7 * i), s_exp[i % 4]});
      tick();
    end
    upd_valid = 1'b0; upd_is_cond_br = 1'b0;
    drain();
    chk("stream_drop", 32'(drop_count), 32'd2);
    check_log("stream_log");

    // Non-conditional results are ignored.
    upd_valid = 1'b1; upd_is_cond_br = 1'b0; upd_index = 10'h033;
    upd_prev_value = 2'd1; upd_exec_taken = 1'b1;
    #1;
    chk("filter_wr_en", 32'(wr_en), 32'd0);
    tick();
    upd_valid = 1'b0;
    #1;
    chk("filter_empty", 32'(q_empty), 32'd1);
    chk("filter_count", 32'(q_count), 32'd0);
    tick();
    check_log("filter_log");

    // Conditional push into an empty queue, no conflict.
    upd_valid = 1'b1; upd_is_cond_br = 1'b1; upd_index = 10'h0AB;
    upd_prev_value = 2'd1; upd_exec_taken = 1'b1;
    #1;
`ifdef RSD_PHT_UPDATE_QUEUE_BYPASS_EN
    chk("byp_wr_en", 32'(wr_en), 32'd1);
    chk("byp_wr_index", 32'(wr_index), 32'h0AB);
    chk("byp_wr_value", 32'(wr_value), 32'd2);
    tick();
    upd_valid = 1'b0; upd_is_cond_br = 1'b0;
    #1;
    chk("byp_count", 32'(q_count), 32'd0);
`else
    chk("nobyp_wr_en", 32'(wr_en), 32'd0);
    tick();
    upd_valid = 1'b0; upd_is_cond_br = 1'b0;
    #1;
    chk("nobyp_count", 32'(q_count), 32'd1);
    chk("nobyp_wr_en_next", 32'(wr_en), 32'd1);
    tick();
`endif
    exp_q.push_back({10'h0AB, 2'd2});
    check_log("byp_log");

    // Reset mid-operation discards queued entries.
    rd_valid = 1'b1; rd_index = 10'h000;
    for (int i = 0; i < 5; i++) push_one(10'(10'h010 + 2 * i), 2'd1, 1'b1);
    chk("mid_count5", 32'(q_count), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(q_count), 32'd0);
    chk("mid_rst_empty", 32'(q_empty), 32'd1);
    tick();
    rst_n = 1'b1; rd_valid = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_wr_en", 32'(wr_en), 32'd0);
    chk("post_rst_drop", 32'(drop_count), 32'd0);
    check_log("post_rst_log");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pht_update_queue.md
Name: pht_update_queue

Overview:
- Drains executed conditional-branch results into the PHT write port; the write-side counterpart of the PHT read/prediction path in fetch.
- Buffers (PHT index, new 2-bit counter) pairs in a circular FIFO.
- Retires one entry per cycle whenever the PHT write does not bank-conflict with the same-cycle fetch-side PHT read.
- Updates are hints: on overflow, an update is dropped and counted. Fetch is never stalled.

Parameters:
QUEUE_SIZE, 32, FIFO depth; power of two, >= 2
PHT_INDEX_WIDTH, 10, PHT index width (log2 of PHT entry count)
PHT_ENTRY_WIDTH, 2, saturating counter width
BANK_BIT_WIDTH, 1, low index bits compared for bank conflict; >= 1
DROP_CNT_WIDTH, 16, width of the dropped-update counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
upd_valid  in  1  branch result valid this cycle
upd_is_cond_br  in  1  result is a conditional branch; non-conditional results are ignored
upd_index  in  PHT_INDEX_WIDTH  PHT index used at prediction
upd_prev_value  in  PHT_ENTRY_WIDTH  counter value read at prediction
upd_exec_taken  in  1  resolved direction
rd_valid  in  1  fetch reads the PHT this cycle
rd_index  in  PHT_INDEX_WIDTH  fetch read index
wr_en  out  1  PHT write strobe
wr_index  out  PHT_INDEX_WIDTH  PHT write index
wr_value  out  PHT_ENTRY_WIDTH  PHT write data
q_count  out  clog2(QUEUE_SIZE)+1  occupancy
q_full  out  1  q_count == QUEUE_SIZE
q_empty  out  1  q_count == 0
drop_count  out  DROP_CNT_WIDTH  saturating count of dropped updates

Behaviour:
- Reset, asynchronous while rst_n=0: head=tail=0, count=0, drop_count=0. Outputs read wr_en=0, wr_index=0, wr_value=0, q_empty=1, q_full=0.
- Reset mid-operation discards all queued entries. Entry RAM contents need no reset.
- Push request: push_req = upd_valid & upd_is_cond_br.
- New counter, computed at push:
  - If exec_taken: prev==MAX(3) ? 3 : prev+1.
  - Else: prev==0 ? 0 : prev-1.
  - Arithmetic is unsigned, PHT_ENTRY_WIDTH bits, never wraps.
- Conflict: conflict = rd_valid & (wr_index[BANK_BIT_WIDTH-1:0] == rd_index[BANK_BIT_WIDTH-1:0]).
- Pop:
  - wr_en = !q_empty & !conflict, combinational from the registered head entry and the current rd_*.
  - wr_index/wr_value = head entry whenever !q_empty, else 0.
  - Pop occurs iff wr_en.
- Push acceptance: accepted iff push_req & (!q_full | pop).
  - Full with a same-cycle pop: push is accepted and count is unchanged.
  - Full without a pop: update dropped; drop_count += 1, saturating at all-ones.
- Latency: an entry pushed in cycle N is at the head at the earliest in cycle N+1. In-order retirement only.
- Pointers: tail advances on accept, head on pop; both wrap modulo QUEUE_SIZE. count +1 / -1 / unchanged for push-only / pop-only / both.
- Persistent conflict leaves the head stalled; pushes continue until full, then drop.
- Coalescing: duplicate indices are not merged; later entries overwrite earlier ones in PHT order.

Optional Feature:
- Macro: RSD_PHT_UPDATE_QUEUE_BYPASS_EN.
- Defined: when q_empty & push_req and the incoming index does not bank-conflict with rd_index (or rd_valid=0), the new counter is written in the same cycle. wr_en=1, wr_index=upd_index, wr_value=new counter, and nothing is enqueued. If it conflicts, the update is enqueued normally.
- Undefined: no bypass; wr_en depends only on registered queue state and rd_*.

Test Plan:
- Reset then idle: q_empty=1, wr_en=0, drop_count=0; assert rst_n=0 with 5 entries queued -> q_count=0 immediately, no wr_en afterward.
- Single push index=0x05, prev=1, taken=1, rd_valid=0 -> next cycle wr_en=1, wr_index=0x05, wr_value=2, then q_empty=1. Repeat with prev=3, taken=1 -> wr_value=3; prev=0, taken=0 -> wr_value=0.
- Conflict stall: queued index=0x04, rd_valid=1, rd_index=0x06 held for 3 cycles -> wr_en=0 for 3 cycles. Change rd_index=0x07 -> wr_en=1, wr_index=0x04.
- Overflow: rd_valid=1, rd_index=0x00, push 34 even indices -> q_full=1 after 32, drop_count=2. Then push with rd_valid=0 -> pop+push, q_count stays 32, drop_count stays 2.
- Ordering/wrap: push 40 entries in streaming mode (rd_valid=0) -> 40 writes in push order, indices and values matching, no drops.
- Filter: upd_valid=1, upd_is_cond_br=0 -> no enqueue. With RSD_PHT_UPDATE_QUEUE_BYPASS_EN defined and the queue empty -> a cond push produces wr_en in the same cycle, q_count stays 0.
